// File: rtl/wishbone_uart_slave.sv
// Wishbone classic slave with a minimal UART-style register map, backed by
// TX/RX byte FIFOs with streaming ports and a registered level interrupt.
module wishbone_uart_slave #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              interrupt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_IER  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_IIR  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_LSR  = ADDR_W'(5);
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t     state;
  logic [1:0] ier;
  logic       tx_ovr, rx_ovr;

  logic [7:0]   tx_mem [FIFO_DEPTH];
  logic [7:0]   rx_mem [FIFO_DEPTH];
  logic [PTR_W:0] tx_wr, tx_rd, rx_wr, rx_rd;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic access, wr_en, rd_en;
  logic tx_push_req, tx_push, tx_pop, tx_ovr_new;
  logic rx_pop, rx_push, rx_ovr_new, lsr_read;
  logic rx_irq, tx_irq;
  logic [7:0] read_byte, iir_val, lsr_val;
  logic unused_bits;

  assign unused_bits = ^{wb_dat_i[DATA_W-1:8], wb_sel_i[3:1]};

  // Full when the index bits match but the wrap bits differ.
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[PTR_W] != tx_rd[PTR_W]) && (tx_wr[PTR_W-1:0] == tx_rd[PTR_W-1:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[PTR_W] != rx_rd[PTR_W]) && (rx_wr[PTR_W-1:0] == rx_rd[PTR_W-1:0]);

  assign tx_data_o  = tx_mem[tx_rd[PTR_W-1:0]];
  assign tx_valid_o = !tx_empty;
  assign rx_ready_o = !rx_full;

  assign access   = (state == IDLE) && wb_cyc_i && wb_stb_i;
  assign wr_en    = access && wb_we_i && wb_sel_i[0];
  assign rd_en    = access && !wb_we_i;
  assign lsr_read = rd_en && (wb_adr_i == ADDR_LSR);

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign tx_pop      = tx_valid_o && tx_ready_i;
  assign tx_push_req = wr_en && (wb_adr_i == ADDR_DATA);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_ovr_new  = tx_push_req && tx_full && !tx_pop;

  assign rx_pop     = rd_en && (wb_adr_i == ADDR_DATA) && !rx_empty;
  assign rx_push    = rx_valid_i && (!rx_full || rx_pop);
  assign rx_ovr_new = rx_valid_i && rx_full && !rx_pop;

  assign rx_irq  = ier[0] && !rx_empty;
  assign tx_irq  = ier[1] && tx_empty;
  assign iir_val = rx_irq ? 8'h04 : (tx_irq ? 8'h02 : 8'h01);
  assign lsr_val = {1'b0, tx_full, tx_empty, tx_ovr, 2'b00, rx_ovr, !rx_empty};

  always_comb begin
    read_byte = 8'h00;
    case (wb_adr_i)
      ADDR_DATA: read_byte = rx_empty ? 8'h00 : rx_mem[rx_rd[PTR_W-1:0]];
      ADDR_IER:  read_byte = {6'b0, ier};
      ADDR_IIR:  read_byte = iir_val;
      ADDR_LSR:  read_byte = lsr_val;
      default:   read_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            wb_ack_o <= 1'b1;
            wb_dat_o <= wb_we_i ? '0 : DATA_W'(read_byte);
            state    <= ACK;
          end
        end
        ACK: begin
          wb_ack_o <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          wb_ack_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[PTR_W-1:0]] <= wb_dat_i[7:0];
    if (rx_push) rx_mem[rx_wr[PTR_W-1:0]] <= rx_data_i;
  end

  // A new overrun on the LSR read edge takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ier       <= 2'b00;
      tx_ovr    <= 1'b0;
      rx_ovr    <= 1'b0;
      tx_wr     <= '0;
      tx_rd     <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      interrupt <= 1'b0;
    end else begin
      if (wr_en && (wb_adr_i == ADDR_IER)) ier <= wb_dat_i[1:0];
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      if (tx_ovr_new)    tx_ovr <= 1'b1;
      else if (lsr_read) tx_ovr <= 1'b0;
      if (rx_ovr_new)    rx_ovr <= 1'b1;
      else if (lsr_read) rx_ovr <= 1'b0;
      interrupt <= rx_irq || tx_irq;
    end
  end

endmodule

// File: doc/wishbone_uart_slave.md
Name: wishbone_uart_slave

Overview:
- Wishbone classic slave (responder) presenting a minimal UART-style register map to a Wishbone master: the gateway, its config/transfer engines, or a bench master.
- Backs the register map with 8-bit TX and RX byte FIFOs and streaming byte ports.
- Drives a level interrupt.
- Used as the device-side end of the UART Wishbone link: as a stand-in for the UART IP in gateway simulation, and as an RC-side mailbox.

Parameters:
- ADDR_W, 5, Wishbone address width (matches UART_ADDR_WIDTH).
- DATA_W, 32, Wishbone data width. Registers occupy bits [7:0]; upper bits read 0.
- FIFO_DEPTH, 16, entries per FIFO. Power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  ADDR_W  register address (byte address).
- wb_dat_i  in  DATA_W  write data.
- wb_sel_i  in  4  byte select. Writes take effect only if sel[0]=1.
- wb_dat_o  out  DATA_W  read data, registered.
- wb_ack_o  out  1  one-cycle acknowledge.
- tx_data_o  out  8  TX FIFO head byte.
- tx_valid_o  out  1  TX FIFO not empty.
- tx_ready_i  in  1  consumer pops on valid&ready.
- rx_data_i  in  8  incoming byte.
- rx_valid_i  in  1  producer pushes on valid&ready.
- rx_ready_o  out  1  RX FIFO not full.
- interrupt  out  1  level interrupt, registered.

Behaviour:
- Reset values (async, rst=1):
  - wb_ack_o=0, wb_dat_o=0, interrupt=0.
  - FSM=IDLE; both FIFOs empty; IER=0x00; overrun flags=0.
  - Resulting outputs: tx_valid_o=0, rx_ready_o=1.
  - Reset mid-transaction aborts it: no ack, no side effects.
- FSM, two states:
  - IDLE: if cyc&stb, perform the access at the clock edge, register wb_dat_o, set wb_ack_o=1, go to ACK.
  - ACK: wb_ack_o=0, return to IDLE unconditionally.
  - Latency: ack 1 cycle after strobe. Maximum rate: one access per 2 cycles.
  - Strobe dropped before the edge: no access.
- Register map (wb_adr_i):
  - 0x0 DATA:
    - Write pushes wb_dat_i[7:0] into TX FIFO. If TX is full, the byte is dropped and TXOVR is set.
    - Read pops RX FIFO and returns its head. If RX is empty, returns 0x00 and does not pop.
  - 0x1 IER, R/W, bits [1:0] only:
    - bit0 = RX data-available interrupt enable.
    - bit1 = TX empty interrupt enable.
  - 0x2 IIR, read-only:
    - 0x04 if RX interrupt pending.
    - Else 0x02 if TX-empty interrupt pending.
    - Else 0x01.
  - 0x5 LSR, read-only:
    - bit0 = RX not empty.
    - bit1 = RXOVR.
    - bit4 = TXOVR.
    - bit5 = TX empty.
    - bit6 = TX full.
    - Reading LSR clears RXOVR and TXOVR at the ack edge. A new overrun on that same edge wins: the flag stays set.
  - Any other address: read returns 0, write is ignored, ack is still given.
  - Register writes with sel[0]=0 are acked with no effect.
- FIFOs:
  - Pointer width log2(FIFO_DEPTH)+1 with wrap bit; full/empty compare pointers.
  - Simultaneous push and pop on a non-empty FIFO: both occur, count unchanged.
  - TX, full + pop: pop frees the slot in the same cycle as the bus push, so the push succeeds with no TXOVR.
  - RX, full + rx_valid_i: the byte is dropped and RXOVR is set.
  - rx_ready_o deasserts when RX is full. Asserting rx_valid_i while rx_ready_o=0 is the RXOVR case.
  - TX pop occurs on tx_valid_o&tx_ready_i. tx_data_o is the combinational FIFO head.
- Interrupt:
  - interrupt <= (IER[0] & rx_not_empty) | (IER[1] & tx_empty), registered, 1-cycle lag.

Test Plan:
- Reset check: rst pulse mid-IDLE -> ack=0, interrupt=0, tx_valid_o=0, rx_ready_o=1; LSR read returns 0x20.
- TX path: write DATA 0xA5, then 0x3C, with tx_ready_i=0 -> each ack exactly 1 cycle after stb; tx_valid_o=1, tx_data_o=0xA5. Then tx_ready_i=1 for 2 cycles -> bytes A5, 3C in order; LSR=0x20.
- TX overflow: 17 DATA writes with tx_ready_i=0 (depth 16) -> LSR=0x50. After that read, the next LSR read returns 0x40. The 17th byte is never emitted.
- RX path: push 0x11, 0x22 via rx_valid_i -> LSR bit0=1; DATA reads return 0x11 then 0x22; a third read returns 0x00 with no underflow.
- Interrupt: IER=0x01, push one RX byte -> interrupt=1 within 2 cycles, IIR=0x04. Read DATA -> IIR reads 0x02 if IER=0x03, else 0x01.
- Edge cases: undefined address 0x7 read -> 0 with ack. Write with sel=0 -> acked, IER unchanged. Simultaneous RX push on a full FIFO during DATA read -> push accepted, no RXOVR.
